// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcodes, ALU_op codes, mux select constants and the control word layout.
package mips_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // ALU_op codes, shared with ALU_control
  localparam logic [SEL_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRC_B_REG     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_source;
    logic             branch_ne;
    logic             instr_done;
    logic             illegal_op;
  } ctrl_word_t;

  function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational map from FSM state to the datapath control word.
// mem_ready gates the FETCH/MEM_WRITE completion strobes; tie high without waits.
module multicycle_ctrl_decode
  import mips_pkg::*;
(
  input  state_e                state,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  mem_ready,
  output ctrl_word_t            ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.alu_src_b = SRC_B_FOUR;
        ctrl_c.pc_source = PC_SRC_ALU;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b  = SRC_B_IMM_SH2;
        ctrl_c.illegal_op = !is_supported(opcode);
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_c.mem_write  = 1'b1;
        ctrl_c.iord       = 1'b1;
        ctrl_c.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRC_B_REG;
        ctrl_c.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRC_B_REG;
        ctrl_c.alu_op        = ALU_OP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PC_SRC_ALUOUT;
        ctrl_c.branch_ne     = (opcode == OP_BNE);
        ctrl_c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_source  = PC_SRC_JUMP;
        ctrl_c.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state
// logic and reset masking. MULTICYCLE_MEM_WAIT_EN adds mem_ready handshaking.
module multicycle_control
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  opcode,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic                 mem_ready,
`endif
  output logic                 PC_write,
  output logic                 PC_write_cond,
  output logic                 IorD,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 IR_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 ALU_src_A,
  output logic [SEL_W-1:0]     ALU_src_B,
  output logic [SEL_W-1:0]     ALU_op,
  output logic [SEL_W-1:0]     PC_source,
  output logic                 branch_ne,
  output logic [STATE_W-1:0]   state,
  output logic                 instr_done,
  output logic                 illegal_op
);

  state_e     state_q;
  state_e     state_d;
  state_e     dec_state;
  logic       is_store_q;
  logic       mem_rdy;
  ctrl_word_t ctrl;
  ctrl_word_t ctrl_out;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // lw/sw is remembered at DECODE so MEM_ADDR never looks at the opcode again
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_store_q <= (opcode == OP_SW);
      end
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDI_EXEC;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_rdy ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_rdy ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // During reset the selects show FETCH values while every write strobe is held low
  assign dec_state = rst ? S_FETCH : state_q;

  multicycle_ctrl_decode u_decode (
    .state     (dec_state),
    .opcode    (opcode),
    .mem_ready (mem_rdy),
    .ctrl_c    (ctrl)
  );

  always_comb begin
    ctrl_out = ctrl;
    if (rst) begin
      ctrl_out.pc_write      = 1'b0;
      ctrl_out.pc_write_cond = 1'b0;
      ctrl_out.ir_write      = 1'b0;
      ctrl_out.mem_read      = 1'b0;
      ctrl_out.mem_write     = 1'b0;
      ctrl_out.reg_write     = 1'b0;
      ctrl_out.instr_done    = 1'b0;
      ctrl_out.illegal_op    = 1'b0;
    end
  end

  assign PC_write      = ctrl_out.pc_write;
  assign PC_write_cond = ctrl_out.pc_write_cond;
  assign IorD          = ctrl_out.iord;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign IR_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign ALU_src_A     = ctrl_out.alu_src_a;
  assign ALU_src_B     = ctrl_out.alu_src_b;
  assign ALU_op        = ctrl_out.alu_op;
  assign PC_source     = ctrl_out.pc_source;
  assign branch_ne     = ctrl_out.branch_ne;
  assign instr_done    = ctrl_out.instr_done;
  assign illegal_op    = ctrl_out.illegal_op;
  assign state         = STATE_W'(state_q);

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath, directly upstream of `ALU_control`. It decodes the IR opcode and sequences every instruction through fetch, decode, execute, memory and write-back states. It drives all datapath enables and mux selects, including the 2-bit `ALU_op` that `ALU_control` consumes. One state per clock; the outputs are a Moore function of the current state.

## Interface
- No parameters.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 6: `IR[31:26]`, valid from DECODE onward.
- `mem_ready` input 1: memory access complete. Present only with `MULTICYCLE_MEM_WAIT_EN`.
- `PC_write`, `PC_write_cond`, `IorD`, `mem_read`, `mem_write`, `IR_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `ALU_src_A`: output 1 each, datapath controls.
- `ALU_src_B` output 2: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `ALU_op` output 2: to `ALU_control`. 00 add, 01 sub, 10 funct.
- `PC_source` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `branch_ne` output 1: invert the zero flag for bne.
- `state` output 4: current state, for debug.
- `instr_done` output 1: high in the final state of each instruction.
- `illegal_op` output 1: high in DECODE when the opcode is unsupported.

## Operation
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, bne 000101, addi 001000, j 000010.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11.
- Encodings 12–15 go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEM_ADDR (lw, sw), EXECUTE (R), BRANCH (beq, bne), JUMP (j), ADDI_EXEC (addi), FETCH (other).
  - MEM_ADDR→MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ→MEM_WB→FETCH.
  - MEM_WRITE→FETCH.
  - EXECUTE→ALU_WB→FETCH.
  - ADDI_EXEC→ADDI_WB→FETCH.
  - BRANCH→FETCH; JUMP→FETCH.
- Per-state outputs. Any output not listed is 0, and `ALU_op` defaults to 00.
  - FETCH: `mem_read`=1, `IorD`=0, `IR_write`=1, `ALU_src_A`=0, `ALU_src_B`=01, `PC_source`=00, `PC_write`=1.
  - DECODE: `ALU_src_A`=0, `ALU_src_B`=11.
  - MEM_ADDR, ADDI_EXEC: `ALU_src_A`=1, `ALU_src_B`=10.
  - MEM_READ: `mem_read`=1, `IorD`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1.
  - MEM_WRITE: `mem_write`=1, `IorD`=1, `instr_done`=1.
  - EXECUTE: `ALU_src_A`=1, `ALU_src_B`=00, `ALU_op`=10.
  - ALU_WB: `reg_write`=1, `reg_dst`=1, `instr_done`=1.
  - ADDI_WB: `reg_write`=1, `reg_dst`=0, `instr_done`=1.
  - BRANCH: `ALU_src_A`=1, `ALU_src_B`=00, `ALU_op`=01, `PC_write_cond`=1, `PC_source`=01, `branch_ne`=(opcode==000101), `instr_done`=1.
  - JUMP: `PC_write`=1, `PC_source`=10, `instr_done`=1.
- Illegal opcode: `illegal_op`=1 for the DECODE cycle only, then FETCH. No architectural write occurs.

## Timing
- Instruction latency in cycles: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3, illegal 2.
- Reset: `state` becomes FETCH at the first edge with `rst`=1 and stays FETCH while `rst` is held.
- While `rst`=1, `PC_write`, `PC_write_cond`, `IR_write`, `mem_read`, `mem_write`, `reg_write`, `instr_done` and `illegal_op` are forced to 0. All other outputs show their FETCH values.
- Reset asserted mid-instruction: the instruction is abandoned with no further writes. The first cycle after `rst` falls is FETCH.
- `opcode` is sampled only in DECODE and BRANCH. IR is stable because `IR_write` is set only in FETCH.

## Configuration
- `MULTICYCLE_MEM_WAIT_EN` defined:
  - Adds the `mem_ready` port.
  - FETCH, MEM_READ and MEM_WRITE hold until `mem_ready`=1.
  - In FETCH, `PC_write` and `IR_write` are gated by `mem_ready`.
  - In MEM_WRITE, `mem_write` stays high during the wait and `instr_done` is gated by `mem_ready`.
  - `mem_read` stays high while waiting.
  - Latency grows by the wait cycles.
- Undefined: no `mem_ready` port; every access completes in one cycle.

## Structure
- Shared package `mips_pkg` holds the state enum, the opcode constants, the `ALU_op` codes (00/01/10) and the `ALU_src_B`/`PC_source` select constants. The same `ALU_op` codes are used by `ALU_control`.
- One sub-module, `multicycle_ctrl_decode`: a purely combinational map from state to control word. The top level holds the state register and next-state logic.

## Test plan
- Reset: hold `rst` 3 cycles mid-lw (state=3), release. Expect state=0, all write enables 0 during reset, then FETCH outputs.
- lw then R-type: opcode 100011 then 000000. Expect states 0,1,2,3,4 then 0,1,6,7; `ALU_op`=10 only in EXECUTE; `instr_done` only in states 4 and 7.
- beq and bne: opcode 000100 then 000101. Expect 3-cycle sequences 0,1,8; `PC_write_cond`=1 and `ALU_op`=01 in BRANCH; `branch_ne` 0 then 1.
- addi, j, sw: expect 0,1,10,11 (`reg_dst`=0, `reg_write`=1); then 0,1,9 (`PC_source`=10); then 0,1,2,5 (`mem_write`=1, `IorD`=1).
- Illegal opcode 111111: `illegal_op`=1 in DECODE only, next state 0, no `reg_write`, `mem_write` or `PC_write_cond`.
- With `MULTICYCLE_MEM_WAIT_EN`: `mem_ready`=0 for 2 cycles in FETCH and in MEM_READ. Expect lw in 9 cycles, with `PC_write`/`IR_write` high only in the `mem_ready` cycle.
